uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmitter (byte-load / busy interface) between N_REQ
//   requesters. Round-robin arbitration per packet: a winner keeps the grant
//   until it sends a byte flagged last, or until its lock times out. Sits
//   between multiple byte sources (loopback echo, status reporter, etc.) and
//   the single UART TX serialiser driving o_tx.
// PARAMETERS
//   N_REQ         4      number of requesters (2..8)
//   LOCK_TIMEOUT  25000  idle cycles an owner may hold a packet lock (~2 bytes at 9600 baud, 12 MHz)
//   START_TIMEOUT 16     cycles allowed for i_tx_busy to rise after a load
// PORTS
//   i_clk          in   1         system clock (12 MHz)
//   i_rst          in   1         synchronous reset, active high
//   i_req_valid    in   N_REQ     requester n has a byte pending
//   i_req_data     in   8*N_REQ   byte of requester n at [8n+7:8n]
//   i_req_last     in   N_REQ     byte of requester n ends its packet
//   o_req_ack      out  N_REQ     one-cycle pulse: byte of requester n taken
//   o_grant        out  N_REQ     one-hot current owner; 0 when none
//   o_tx_data      out  8         byte to UART TX
//   o_tx_load      out  1         one-cycle load strobe to UART TX
//   i_tx_busy      in   1         UART TX shifting a frame
//   o_start_err    out  1         sticky: busy failed to rise within START_TIMEOUT
//   o_bytes_sent   out  16        bytes loaded since reset, wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (sync, i_rst=1 at posedge): state IDLE, all outputs 0, rr pointer=0,
//     lock cleared, counters 0. Reset mid-frame abandons the byte; no ack issued.
//   Requester rule: hold valid/data/last stable until ack; ack only while valid.
//   FSM:
//   IDLE: if lock held: owner valid & !busy -> LOAD; owner invalid counts
//     lock timer, at LOCK_TIMEOUT clear lock, o_grant=0, pointer=owner+1.
//     If no lock: any valid & !busy -> pick first valid at/after pointer
//     (wrap N_REQ-1 -> 0), set o_grant, -> LOAD. Otherwise stay.
//   LOAD (1 cycle): o_tx_load=1, o_tx_data=winner byte (registered),
//     o_req_ack[winner]=1, o_bytes_sent++; lock=!last; -> WAIT_BUSY.
//   WAIT_BUSY: busy=1 -> WAIT_DONE; START_TIMEOUT cycles elapsed with busy=0
//     -> set o_start_err, -> RELEASE.
//   WAIT_DONE: busy=0 -> RELEASE.
//   RELEASE (1 cycle): if lock -> IDLE keeping grant, lock timer=0;
//     else o_grant=0, pointer=winner+1 (wrap) -> IDLE.
//   Latency: valid seen in IDLE -> load/ack on next clock edge (1 cycle).
//   Non-owner requests are never acked while a lock is held.
//   Simultaneous requests: only the rr-order winner acked; others wait.
//   Valid dropping before ack (protocol violation): ignored unless present at
//     IDLE decision cycle; byte latched at decision cycle is the one sent.
//   o_tx_load, o_req_ack never asserted two consecutive cycles.
// TESTING
//   1. Reset: i_rst=1 2 cycles with all valid=1 -> no load/ack, outputs 0.
//   2. Single: req0 byte 0x55 last=1 -> one ack[0], load with 0x55, grant
//      0001 until busy falls, then 0000; o_bytes_sent=1.
//   3. Round robin: valid=1111 all last=1, bytes 0xA0..0xA3 -> acks in order
//      0,1,2,3,0; o_tx data sequence A0,A1,A2,A3.
//   4. Lock: req1 sends 0x10,0x11(last) while req2 valid -> 0x10,0x11 sent
//      before req2's byte; no ack[2] until grant to req1 releases.
//   5. Lock timeout: req3 sends 0x33 last=0 then drops valid -> grant held
//      LOCK_TIMEOUT cycles, then cleared; pending req0 then served.
//   6. Start error: i_tx_busy tied 0 -> after load, 16 cycles later o_start_err=1,
//      FSM returns IDLE and serves next request; mid-frame reset clears all.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX byte-load/busy interface between N_REQ requesters, round-robin per packet
// Ports: i_clk, i_rst (sync, active high); i_req_valid/i_req_data/i_req_last per requester (byte n at [8n+7:8n]);
//   o_req_ack one-cycle take pulse; o_grant one-hot owner (0 = none); o_tx_data/o_tx_load drive the UART,
//   i_tx_busy comes back from it; o_start_err sticky when busy never rose; o_bytes_sent wrapping load count.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int LOCK_TIMEOUT  = 25000,
    parameter int START_TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_last,
    output logic [N_REQ-1:0]   o_req_ack,
    output logic [N_REQ-1:0]   o_grant,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_load,
    input  logic               i_tx_busy,
    output logic               o_start_err,
    output logic [15:0]        o_bytes_sent
);
    localparam int IW = $clog2(N_REQ);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(START_TIMEOUT + 1);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RELEASE   = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] ptr, win, pick, sel, j;
    logic          found, go, lock, last_r;
    logic [LW-1:0] lock_cnt;
    logic [SW-1:0] start_cnt;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(N_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Scan from the far end back toward ptr so the last hit is the first valid at/after ptr.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        j     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N_REQ);
            if (i_req_valid[j]) begin
                found = 1'b1;
                pick  = j;
            end
        end
        sel = lock ? win : pick;
        go  = !i_tx_busy && (lock ? i_req_valid[win] : found);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            ptr          <= '0;
            win          <= '0;
            lock         <= 1'b0;
            last_r       <= 1'b0;
            lock_cnt     <= '0;
            start_cnt    <= '0;
            o_req_ack    <= '0;
            o_grant      <= '0;
            o_tx_data    <= '0;
            o_tx_load    <= 1'b0;
            o_start_err  <= 1'b0;
            o_bytes_sent <= '0;
        end else begin
            o_tx_load <= 1'b0;
            o_req_ack <= '0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= LOAD;
                        win       <= sel;
                        o_grant   <= N_REQ'(1) << sel;
                        o_req_ack <= N_REQ'(1) << sel;
                        o_tx_load <= 1'b1;
                        o_tx_data <= i_req_data[{sel, 3'b000} +: 8];
                        last_r    <= i_req_last[sel];
                    end else if (lock && !i_req_valid[win]) begin
                        // An owner that stops presenting bytes loses its packet lock after LOCK_TIMEOUT idle cycles.
                        if (lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
                            lock     <= 1'b0;
                            o_grant  <= '0;
                            ptr      <= next_idx(win);
                            lock_cnt <= '0;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                end
                LOAD: begin
                    o_bytes_sent <= o_bytes_sent + 16'd1;
                    lock         <= !last_r;
                    start_cnt    <= '0;
                    state        <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (start_cnt == SW'(START_TIMEOUT - 1)) begin
                        o_start_err <= 1'b1;
                        state       <= RELEASE;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                WAIT_DONE: state <= i_tx_busy ? WAIT_DONE : RELEASE;
                RELEASE: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                    if (!lock) begin
                        o_grant <= '0;
                        ptr     <= next_idx(win);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of uart_tx_arbiter against a behavioural model
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int LT = 60;
    localparam int ST = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] valid, last, ack, grant;
    logic [8*N-1:0] data;
    logic [7:0]   tx_data;
    logic         tx_load, busy, start_err;
    logic [15:0]  sent;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(LT), .START_TIMEOUT(ST)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data(data), .i_req_last(last),
        .o_req_ack(ack), .o_grant(grant), .o_tx_data(tx_data), .o_tx_load(tx_load),
        .i_tx_busy(busy), .o_start_err(start_err), .o_bytes_sent(sent)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // per-requester pending bytes, {last, data}
    logic [8:0] rq [N][$];
    int log_idx[$];
    logic [7:0] log_dat[$];
    int log_cyc[$];

    // UART stand-in
    int u_dly = 0, u_len = 0, u_cnt = 0;
    bit stuck = 0, rnd = 0;
    int fix_d = 2, fix_len = 3;

    // behavioural model of the arbiter
    typedef enum int {M_IDLE, M_LOADING, M_AWAIT_START, M_SHIFTING, M_RELEASING} mph_t;
    mph_t ph = M_IDLE;
    int owner = -1, ptr = 0, idle_cnt = 0, wait_cnt = 0;
    bit locked = 0, m_last = 0, m_err = 0;
    logic [15:0] m_sent = '0;
    logic [7:0]  m_data = '0;
    logic        e_load = 1'b0;
    logic [N-1:0] e_ack = '0, e_grant = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int rr_pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Advances the model over the clock edge that just happened, using the inputs the DUT saw there.
    task automatic model_step();
        int w;
        e_load = 1'b0;
        e_ack  = '0;
        if (rst) begin
            ph = M_IDLE; owner = -1; ptr = 0; idle_cnt = 0; wait_cnt = 0;
            locked = 0; m_err = 0; m_sent = '0;
        end else begin
            case (ph)
                M_IDLE: begin
                    w = locked ? owner : rr_pick(valid, ptr);
                    if (!busy && w >= 0 && valid[w]) begin
                        owner = w; m_data = data[8*w +: 8]; m_last = last[w];
                        e_load = 1'b1; e_ack[w] = 1'b1; ph = M_LOADING;
                    end else if (locked && !valid[owner]) begin
                        idle_cnt++;
                        if (idle_cnt == LT) begin
                            locked = 0; ptr = (owner + 1) % N; owner = -1;
                        end
                    end
                end
                M_LOADING: begin
                    m_sent = m_sent + 16'd1; locked = !m_last; wait_cnt = 0; ph = M_AWAIT_START;
                end
                M_AWAIT_START: begin
                    if (busy) ph = M_SHIFTING;
                    else begin
                        wait_cnt++;
                        if (wait_cnt == ST) begin m_err = 1; ph = M_RELEASING; end
                    end
                end
                M_SHIFTING: if (!busy) ph = M_RELEASING;
                default: begin
                    idle_cnt = 0;
                    if (!locked) begin ptr = (owner + 1) % N; owner = -1; end
                    ph = M_IDLE;
                end
            endcase
        end
        e_grant = '0;
        if (owner >= 0) e_grant[owner] = 1'b1;
    endtask

    task automatic uart_step();
        if (tx_load) begin
            u_dly = (stuck || (rnd && $urandom_range(0, 15) == 0)) ? 0 : (rnd ? int'($urandom_range(1, 4)) : fix_d);
            u_len = rnd ? int'($urandom_range(1, 6)) : fix_len;
        end else if (u_dly > 0) begin
            u_dly--;
            if (u_dly == 0) begin busy = 1'b1; u_cnt = u_len; end
        end else if (busy) begin
            u_cnt--;
            if (u_cnt == 0) busy = 1'b0;
        end
    endtask

    task automatic req_step();
        for (int n = 0; n < N; n++) begin
            if (ack[n] && rq[n].size() > 0) void'(rq[n].pop_front());
            valid[n] = rq[n].size() > 0;
            {last[n], data[8*n +: 8]} = valid[n] ? rq[n][0] : 9'h0;
        end
    endtask

    task automatic tick();
        int w;
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        vectors++;
        if ({tx_load, ack, grant, start_err, sent} !== {e_load, e_ack, e_grant, m_err, m_sent} ||
            (e_load && tx_data !== m_data)) begin
            miscompares++;
            $display("FAIL cycle %0d load/ack/grant/err/sent/data: got %b/%b/%b/%b/%0d/%h, expected %b/%b/%b/%b/%0d/%h",
                     cyc, tx_load, ack, grant, start_err, sent, tx_data, e_load, e_ack, e_grant, m_err, m_sent, m_data);
        end
        if (tx_load) begin
            w = -1;
            for (int n = 0; n < N; n++) if (ack[n]) w = n;
            log_idx.push_back(w);
            log_dat.push_back(tx_data);
            log_cyc.push_back(cyc);
        end
        uart_step();
        req_step();
    endtask

    function automatic bit rq_empty();
        for (int n = 0; n < N; n++) if (rq[n].size() > 0) return 0;
        return 1;
    endfunction

    task automatic drain(string name, int max);
        int k = 0;
        while (k < max && !(rq_empty() && ph == M_IDLE && !locked && !busy && u_dly == 0)) begin
            tick();
            k++;
        end
        check(name, 64'(k < max), 1);
    endtask

    task automatic wait_load(string name, int max);
        int k = 0;
        do begin tick(); k++; end while (!tx_load && k < max);
        check(name, tx_load, 1);
    endtask

    task automatic do_reset(int n);
        rst = 1'b1; busy = 1'b0; u_dly = 0; u_cnt = 0;
        repeat (n) tick();
        rst = 1'b0;
        log_idx.delete(); log_dat.delete(); log_cyc.delete();
    endtask

    task automatic check_log(string name, int n, int ei[8], logic [7:0] ed[8]);
        check({name, "_count"}, log_idx.size(), n);
        for (int i = 0; i < n && i < log_idx.size(); i++) begin
            check($sformatf("%s_idx%0d", name, i), log_idx[i], ei[i]);
            check($sformatf("%s_dat%0d", name, i), log_dat[i], ed[i]);
        end
    endtask

    initial begin
        int ei[8];
        logic [7:0] ed[8];
        rst = 1'b1; valid = '0; data = '0; last = '0; busy = 1'b0;

        // 1: reset with every requester valid
        for (int n = 0; n < N; n++) rq[n].push_back(9'h1FF);
        repeat (3) tick();
        check("t1_load", tx_load, 0);
        check("t1_ack", ack, 0);
        check("t1_grant", grant, 0);
        check("t1_data", tx_data, 0);
        check("t1_err", start_err, 0);
        check("t1_sent", sent, 0);
        for (int n = 0; n < N; n++) rq[n].delete();
        tick();
        do_reset(1);

        // 2: single byte
        rq[0].push_back(9'h155);
        wait_load("t2_load", 20);
        check("t2_ack", ack, 4'b0001);
        check("t2_data", tx_data, 8'h55);
        tick();
        check("t2_grant_held", grant, 4'b0001);
        drain("t2_drain", 100);
        check("t2_grant_free", grant, 0);
        check("t2_sent", sent, 1);

        // 3: round robin
        do_reset(1);
        rq[0].push_back(9'h1A0); rq[0].push_back(9'h1B0);
        rq[1].push_back(9'h1A1); rq[2].push_back(9'h1A2); rq[3].push_back(9'h1A3);
        drain("t3_drain", 300);
        ei = '{0, 1, 2, 3, 0, 0, 0, 0};
        ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'h0, 8'h0, 8'h0};
        check_log("t3", 5, ei, ed);
        check("t3_sent", sent, 5);

        // 4: packet lock holds off a competing requester
        do_reset(1);
        rq[1].push_back(9'h010); rq[1].push_back(9'h111); rq[2].push_back(9'h120);
        drain("t4_drain", 300);
        ei = '{1, 1, 2, 0, 0, 0, 0, 0};
        ed = '{8'h10, 8'h11, 8'h20, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        check_log("t4", 3, ei, ed);

        // 5: lock timeout
        do_reset(1);
        rq[3].push_back(9'h033);
        wait_load("t5_load", 20);
        rq[0].push_back(9'h100);
        repeat (20) tick();
        check("t5_grant_locked", grant, 4'b1000);
        check("t5_no_second", log_idx.size(), 1);
        drain("t5_drain", LT + 100);
        ei = '{3, 0, 0, 0, 0, 0, 0, 0};
        ed = '{8'h33, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        check_log("t5", 2, ei, ed);
        if (log_cyc.size() == 2) check("t5_gap", log_cyc[1] - log_cyc[0], LT + 8);

        // 6: start error, then mid-frame reset
        do_reset(1);
        stuck = 1;
        rq[1].push_back(9'h1C1); rq[2].push_back(9'h1C2);
        drain("t6_drain", 200);
        check("t6_err", start_err, 1);
        ei = '{1, 2, 0, 0, 0, 0, 0, 0};
        ed = '{8'hC1, 8'hC2, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        check_log("t6", 2, ei, ed);
        if (log_cyc.size() == 2) check("t6_gap", log_cyc[1] - log_cyc[0], ST + 3);
        stuck = 0;
        rq[0].push_back(9'h1D0);
        wait_load("t6_load", 20);
        repeat (2) tick();
        do_reset(1);
        check("t6_rst_err", start_err, 0);
        check("t6_rst_sent", sent, 0);
        check("t6_rst_grant", grant, 0);
        check("t6_rst_load", tx_load, 0);

        // random traffic
        rnd = 1;
        for (int i = 0; i < 4000; i++) begin
            for (int n = 0; n < N; n++)
                if (rq[n].size() < 3 && $urandom_range(0, 7) == 0)
                    rq[n].push_back({1'($urandom_range(0, 1)), 8'($urandom)});
            if ($urandom_range(0, 1999) == 0) do_reset($urandom_range(1, 2));
            tick();
        end
        drain("rand_drain", 4 * LT + 400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
